// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the parameterised UART receiver.
//                Holds the receiver state encoding, the default frame
//                constants and the 3-input majority helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int c_DEF_OVERSAMPLE = 16;
    localparam int c_DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Majority of three samples; tolerates one corrupted sample per bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param_if
//  Description : Serial-line / parallel-word bundle of the UART receiver.
//  Ports       : data_tx, rd_ack (towards receiver);
//                active_flag, recieved_flag, data_parll, parity_err,
//                frame_err, overrun_err (from receiver).
//                master = line driver / word consumer, slave = receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_param_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = c_DEF_DATA_BITS
);
    logic                 data_tx;
    logic                 rd_ack;
    logic                 active_flag;
    logic                 recieved_flag;
    logic [DATA_BITS-1:0] data_parll;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output data_tx,
        output rd_ack,
        input  active_flag,
        input  recieved_flag,
        input  data_parll,
        input  parity_err,
        input  frame_err,
        input  overrun_err
    );

    modport slave (
        input  data_tx,
        input  rd_ack,
        output active_flag,
        output recieved_flag,
        output data_parll,
        output parity_err,
        output frame_err,
        output overrun_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_sampler
//  Description : Line synchroniser, oversample counter and 3-sample majority
//                vote for the UART receiver.
//  Ports       : baud_clk, reset      - clock / sync active-high reset
//                rx_i                 - raw asynchronous serial line
//                idle_i               - receiver is idle (arms start detect)
//                start_edge_o         - synchronised falling edge while idle
//                sample_valid_o       - voted bit available this cycle
//                bit_o                - voted bit value
//                bit_end_o            - last oversample count of a bit
//  Revision    : 1.0  initial release
// ============================================================================
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_DEF_OVERSAMPLE
) (
    input  logic baud_clk,
    input  logic reset,
    input  logic rx_i,
    input  logic idle_i,
    output logic start_edge_o,
    output logic sample_valid_o,
    output logic bit_o,
    output logic bit_end_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] c_MID_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] c_MID    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] c_MID_P1 = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] c_LAST   = CW'(OVERSAMPLE - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [1:0]    smp_q;

    assign start_edge_o = idle_i & prev_q & ~sync2_q;

    always_comb begin
        cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
        // Re-align the bit grid to the start edge.
        if (start_edge_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            smp_q   <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            if (cnt_q == c_MID_M1) begin
                smp_q[0] <= sync2_q;
            end
            if (cnt_q == c_MID) begin
                smp_q[1] <= sync2_q;
            end
        end
    end

    // Third sample is taken live, so the vote is ready in the same cycle.
    assign sample_valid_o = (cnt_q == c_MID_P1);
    assign bit_o          = maj3(smp_q[0], smp_q[1], sync2_q);
    assign bit_end_o      = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parameterised UART receiver with optional parity, 1/2 stop
//                bits, single-word holding register and error flags.
//  Ports       : baud_clk - OVERSAMPLE x baud clock
//                reset    - synchronous active-high reset
//                bus      - uart_rx_param_if.slave (line in, word/flags out)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = c_DEF_DATA_BITS,
    parameter int OVERSAMPLE = c_DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           baud_clk,
    input  logic           reset,
    uart_rx_param_if.slave bus
);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [2:0] c_S_IDLE   = ST_IDLE;
    localparam logic [2:0] c_S_START  = ST_START;
    localparam logic [2:0] c_S_DATA   = ST_DATA;
    localparam logic [2:0] c_S_PARITY = ST_PARITY;
    localparam logic [2:0] c_S_STOP   = ST_STOP;

    logic                 start_edge;
    logic                 sample_valid;
    logic                 smp_bit;
    logic                 bit_end;

    logic [2:0]           state_q,    state_d;
    logic [BCW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 stop_err_q, stop_err_d;
    logic                 done;
    logic                 par_err;

    logic                 recv_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 ovr_q;

    uart_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .baud_clk       (baud_clk),
        .reset          (reset),
        .rx_i           (bus.data_tx),
        .idle_i         (state_q == c_S_IDLE),
        .start_edge_o   (start_edge),
        .sample_valid_o (sample_valid),
        .bit_o          (smp_bit),
        .bit_end_o      (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        stop_cnt_d = stop_cnt_q;
        stop_err_d = stop_err_q;
        done       = 1'b0;
        case (state_q)
            c_S_IDLE: begin
                if (start_edge) begin
                    state_d = c_S_START;
                end
            end
            c_S_START: begin
                if (sample_valid && smp_bit) begin
                    state_d = c_S_IDLE;                 // false start
                end else if (bit_end) begin
                    state_d   = c_S_DATA;
                    bit_cnt_d = '0;
                end
            end
            c_S_DATA: begin
                if (sample_valid) begin
                    shift_d   = {smp_bit, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (bit_end && (bit_cnt_q == BCW'(DATA_BITS))) begin
                    state_d    = (PARITY_EN != 0) ? c_S_PARITY : c_S_STOP;
                    stop_cnt_d = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            c_S_PARITY: begin
                if (sample_valid) begin
                    par_bit_d = smp_bit;
                end else if (bit_end) begin
                    state_d    = c_S_STOP;
                    stop_cnt_d = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            c_S_STOP: begin
                if (sample_valid) begin
                    stop_err_d = stop_err_q | ~smp_bit;
                    // Finish right after the last stop sample so a start
                    // edge immediately following the stop bit is caught.
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = c_S_IDLE;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = c_S_IDLE;
        endcase
    end

    assign par_err = (PARITY_EN != 0) & ((^shift_q) ^ par_bit_q ^ 1'(PARITY_ODD));

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_q    <= c_S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            stop_err_q <= 1'b0;
            recv_q     <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop_cnt_q <= stop_cnt_d;
            stop_err_q <= stop_err_d;
            if (done && (!recv_q || bus.rd_ack)) begin
                // Either the holder is empty or is being freed this cycle.
                recv_q <= 1'b1;
                data_q <= shift_q;
                perr_q <= par_err;
                ferr_q <= stop_err_d;
                ovr_q  <= 1'b0;
            end else if (done) begin
                ovr_q <= 1'b1;                          // new word dropped
            end else if (recv_q && bus.rd_ack) begin
                recv_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end
    end

    assign bus.active_flag   = (state_q != c_S_IDLE);
    assign bus.recieved_flag = recv_q;
    assign bus.data_parll    = data_q;
    assign bus.parity_err    = perr_q;
    assign bus.frame_err     = ferr_q;
    assign bus.overrun_err   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Self-checking bench for uart_rx_param. Instance A uses the
//                default 8E1 frame, instance B a 7N2 frame.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(7)) bus_b ();

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .baud_clk (clk),
        .reset    (rst_a),
        .bus      (bus_a)
    );

    uart_rx_param #(
        .DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut_b (
        .baud_clk (clk),
        .reset    (rst_b),
        .bus      (bus_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       pflip;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit 0 is the start bit; even parity bit computed here, optionally flipped.
    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic pflip,
                                            input logic stop);
        logic par;
        par = (^d) ^ pflip;
        return {5'b11111, stop, par, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [6:0] d, input logic s1,
                                            input logic s2);
        return {6'b111111, s2, s1, d, 1'b0};
    endfunction

    task automatic send_line(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) bus_a.data_tx = bits[i];
            else          bus_b.data_tx = bits[i];
            repeat (16) @(negedge clk);
        end
        if (sel == 0) bus_a.data_tx = 1'b1;
        else          bus_b.data_tx = 1'b1;
    endtask

    task automatic ack_a();
        bus_a.rd_ack = 1'b1;
        @(negedge clk);
        bus_a.rd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack_b();
        bus_b.rd_ack = 1'b1;
        @(negedge clk);
        bus_b.rd_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[3] = '{8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.data_tx = 1'b1;
        bus_a.rd_ack  = 1'b0;
        bus_b.data_tx = 1'b1;
        bus_b.rd_ack  = 1'b0;
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (4) @(negedge clk);

        check("rst active",  32'(bus_a.active_flag),   32'd0);
        check("rst recv",    32'(bus_a.recieved_flag), 32'd0);
        check("rst data",    32'(bus_a.data_parll),    32'd0);
        check("rst perr",    32'(bus_a.parity_err),    32'd0);
        check("rst ferr",    32'(bus_a.frame_err),     32'd0);
        check("rst overrun", 32'(bus_a.overrun_err),   32'd0);

        // Table-driven single frames, each acknowledged.
        for (int i = 0; i < 7; i++) begin
            send_line(0, frame_a(vecs[i].data, vecs[i].pflip, vecs[i].stop), 11);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d recv", i),    32'(bus_a.recieved_flag), 32'd1);
            check($sformatf("vec%0d data", i),    32'(bus_a.data_parll),    32'(vecs[i].exp_data));
            check($sformatf("vec%0d perr", i),    32'(bus_a.parity_err),    32'(vecs[i].exp_perr));
            check($sformatf("vec%0d ferr", i),    32'(bus_a.frame_err),     32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d overrun", i), 32'(bus_a.overrun_err),   32'd0);
            check($sformatf("vec%0d active", i),  32'(bus_a.active_flag),   32'd0);
            ack_a();
            check($sformatf("vec%0d ack", i),     32'(bus_a.recieved_flag), 32'd0);
            repeat (32) @(negedge clk);
        end

        // Short low glitch: false start.
        bus_a.data_tx = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch active", 32'(bus_a.active_flag), 32'd1);
        @(negedge clk);
        bus_a.data_tx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch idle",  32'(bus_a.active_flag),   32'd0);
        check("glitch recv",  32'(bus_a.recieved_flag), 32'd0);

        // Back-to-back frames without acknowledge: second word dropped.
        send_line(0, frame_a(8'h11, 1'b0, 1'b1), 11);
        send_line(0, frame_a(8'h22, 1'b0, 1'b1), 11);
        repeat (4) @(negedge clk);
        check("b2b recv",    32'(bus_a.recieved_flag), 32'd1);
        check("b2b data",    32'(bus_a.data_parll),    32'h11);
        check("b2b overrun", 32'(bus_a.overrun_err),   32'd1);
        ack_a();
        check("b2b ack recv",    32'(bus_a.recieved_flag), 32'd0);
        check("b2b ack overrun", 32'(bus_a.overrun_err),   32'd0);
        repeat (32) @(negedge clk);

        // rd_ack coincident with completion: new word loads, no overrun.
        send_line(0, frame_a(8'h3C, 1'b0, 1'b1), 11);
        repeat (32) @(negedge clk);
        fork
            send_line(0, frame_a(8'hC3, 1'b0, 1'b1), 11);
            begin
                repeat (172) @(negedge clk);
                bus_a.rd_ack = 1'b1;
                @(negedge clk);
                bus_a.rd_ack = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("coinc recv",    32'(bus_a.recieved_flag), 32'd1);
        check("coinc data",    32'(bus_a.data_parll),    32'hC3);
        check("coinc overrun", 32'(bus_a.overrun_err),   32'd0);
        ack_a();

        // Instance B: 7 data bits, no parity, two stop bits.
        send_line(1, frame_b(7'h7F, 1'b1, 1'b1), 10);
        repeat (4) @(negedge clk);
        check("b recv", 32'(bus_b.recieved_flag), 32'd1);
        check("b data", 32'(bus_b.data_parll),    32'h7F);
        check("b perr", 32'(bus_b.parity_err),    32'd0);
        check("b ferr", 32'(bus_b.frame_err),     32'd0);
        ack_b();
        repeat (32) @(negedge clk);

        // Second stop bit low.
        send_line(1, frame_b(7'h15, 1'b1, 1'b0), 10);
        repeat (4) @(negedge clk);
        check("b stop2 data", 32'(bus_b.data_parll), 32'h15);
        check("b stop2 ferr", 32'(bus_b.frame_err),  32'd1);
        repeat (32) @(negedge clk);

        // Reset in the middle of DATA, with a word still held.
        send_line(1, frame_b(7'h2A, 1'b1, 1'b1), 4);
        check("b mid active", 32'(bus_b.active_flag), 32'd1);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        check("b rst active",  32'(bus_b.active_flag),   32'd0);
        check("b rst recv",    32'(bus_b.recieved_flag), 32'd0);
        check("b rst data",    32'(bus_b.data_parll),    32'd0);
        check("b rst perr",    32'(bus_b.parity_err),    32'd0);
        check("b rst ferr",    32'(bus_b.frame_err),     32'd0);
        check("b rst overrun", 32'(bus_b.overrun_err),   32'd0);
        rst_b = 1'b0;
        repeat (20) @(negedge clk);
        check("b post idle", 32'(bus_b.active_flag), 32'd0);
        send_line(1, frame_b(7'h2A, 1'b1, 1'b1), 10);
        repeat (4) @(negedge clk);
        check("b post recv", 32'(bus_b.recieved_flag), 32'd1);
        check("b post data", 32'(bus_b.data_parll),    32'h2A);
        check("b post ferr", 32'(bus_b.frame_err),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, baud_clk cycles per bit, even, legal range 8..32.
REQ-003 Parameter PARITY_EN, default 1, 1 = a parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, number of stop bits, 1 or 2.
REQ-006 baud_clk  input  1  single clock, OVERSAMPLE x baud rate; all logic is on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_tx  input  1  asynchronous serial line, idle high, LSB first.
REQ-009 rd_ack  input  1  consumer acknowledge of the held word.
REQ-010 active_flag  output  1  high while a frame is being received (START through STOP).
REQ-011 recieved_flag  output  1  high while a valid word is held in data_parll.
REQ-012 data_parll  output  DATA_BITS  received data word, bit 0 = first data bit on the line.
REQ-013 parity_err  output  1  parity status of the held word.
REQ-014 frame_err  output  1  stop-bit status of the held word.
REQ-015 overrun_err  output  1  sticky flag: a frame completed while recieved_flag was high.

Function
REQ-016 data_tx SHALL pass through a 2-flop synchroniser; all later logic SHALL use the synchronised value only.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-018 IDLE->START SHALL occur on a synchronised high-to-low edge; the oversample counter SHALL clear on that edge.
REQ-019 Each bit SHALL be the majority of the 3 samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; a state advance SHALL occur at count OVERSAMPLE-1, and the counter SHALL then wrap to 0.
REQ-020 If the voted START bit is 1, the FSM SHALL return to IDLE (false start) with no flags changed.
REQ-021 DATA SHALL shift in exactly DATA_BITS voted bits, LSB first, using a bit counter of width clog2(DATA_BITS+1).
REQ-022 Parity SHALL be the XOR of the data bits, XORed with the parity bit and then with PARITY_ODD; a nonzero result SHALL mark a parity error.
REQ-023 STOP SHALL check STOP_BITS voted bits; any 0 SHALL mark a framing error.
REQ-024 Completion SHALL be the cycle after the middle sample of the last stop bit; the FSM SHALL then go to IDLE immediately, allowing a back-to-back start edge.
REQ-025 At completion with recieved_flag=0, the block SHALL load data_parll, parity_err and frame_err, and set recieved_flag in the next cycle.
REQ-026 At completion with recieved_flag=1, the block SHALL discard the new word, keep the held word, and set overrun_err.
REQ-027 rd_ack while recieved_flag=1 SHALL clear recieved_flag next cycle; if a completion occurs in the same cycle, the new word SHALL load and recieved_flag SHALL stay 1 with no overrun.
REQ-028 rd_ack SHALL also clear overrun_err; rd_ack while recieved_flag=0 SHALL have no effect.
REQ-029 active_flag SHALL be 1 exactly in the states START, DATA, PARITY and STOP.

Reset
REQ-030 Reset SHALL force IDLE, the counters to 0 and both synchroniser flops to 1.
REQ-031 Reset SHALL force active_flag=0, recieved_flag=0, data_parll=0, parity_err=0, frame_err=0 and overrun_err=0.
REQ-032 Reset mid-frame SHALL abandon the frame; the next falling edge after release SHALL start a fresh frame.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum and the default OVERSAMPLE and DATA_BITS constants.
REQ-034 Sub-module uart_bit_sampler SHALL contain the synchroniser, the oversample counter and the 3-sample majority vote, and SHALL output a sample_valid strobe and the voted bit.

Verification
REQ-035 Defaults, frame 0x55 with even parity bit 0 and stop 1 -> recieved_flag=1, data_parll=0x55, parity_err=0, frame_err=0.
REQ-036 Same frame with the parity bit flipped -> data_parll=0x55, parity_err=1.
REQ-037 Stop bit driven 0 -> frame_err=1; then line idle, next frame 0xA3 is received correctly after rd_ack.
REQ-038 Low glitch of 4 cycles on the idle line -> false start, active_flag returns to 0, recieved_flag stays 0.
REQ-039 Two back-to-back frames 0x11, 0x22 with no rd_ack -> data_parll=0x11, overrun_err=1; rd_ack clears both flags.
REQ-040 DATA_BITS=7, PARITY_EN=0, STOP_BITS=2, frame 0x7F -> data_parll=0x7F; reset asserted during DATA of a second frame -> all outputs 0.
